vedic_mul32_seq: RTL and testbench

Sequential 32x32 unsigned multiplier that time-shares one vedic_16x16 core across four partial-product steps and accumulates them into a 64-bit result. It has a valid/ready handshake on both input and output sides. It lets datapaths that cannot afford a full 32x32 Vedic tree, four 16x16 cores plus a 48-bit adder stage, obtain 64-bit products at one result per 6 cycles.

---
 rtl/vedic_mul32_seq.sv | 192 +++++++++++++++++++
 tb/tb_vedic_mul32_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul32_seq.sv
// Sequential 32x32 unsigned multiplier: one combinational Vedic 16x16 core is
// time-shared over four partial-product steps and accumulated into 64 bits.

// Recursive Vedic multiplier: four half-width products combined by the
// vertical/crosswise rule, bottoming out in a 2x2 gate-level cell.
module vedic_mul_n #(
    parameter int W = 16
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);
    generate
        if (W == 2) begin : g_base
            logic crossA;
            logic crossB;
            logic high;
            logic carry;
            assign crossA = a_i[1] & b_i[0];
            assign crossB = a_i[0] & b_i[1];
            assign high   = a_i[1] & b_i[1];
            assign carry  = crossA & crossB;
            assign p_o[0] = a_i[0] & b_i[0];
            assign p_o[1] = crossA ^ crossB;
            assign p_o[2] = high ^ carry;
            assign p_o[3] = high & carry;
        end else begin : g_split
            localparam int H = W / 2;
            logic [W-1:0] prodLL;
            logic [W-1:0] prodHL;
            logic [W-1:0] prodLH;
            logic [W-1:0] prodHH;
            logic [W:0]   crossSum;

            vedic_mul_n #(.W(H)) uLL (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(prodLL));
            vedic_mul_n #(.W(H)) uHL (.a_i(a_i[W-1:H]), .b_i(b_i[H-1:0]), .p_o(prodHL));
            vedic_mul_n #(.W(H)) uLH (.a_i(a_i[H-1:0]), .b_i(b_i[W-1:H]), .p_o(prodLH));
            vedic_mul_n #(.W(H)) uHH (.a_i(a_i[W-1:H]), .b_i(b_i[W-1:H]), .p_o(prodHH));

            // Crosswise terms share one weight, so add them before aligning.
            assign crossSum = {1'b0, prodHL} + {1'b0, prodLH};
            assign p_o = {prodHH, prodLL} + {{(H-1){1'b0}}, crossSum, {H{1'b0}}};
        end
    endgenerate
endmodule

module vedic_16x16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] p_o
);
    vedic_mul_n #(.W(16)) uCore (.a_i(a_i), .b_i(b_i), .p_o(p_o));
endmodule

module vedic_mul32_seq #(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [1:0]  step_q,     step_d;
    logic [63:0] acc_q,      acc_d;
    logic [31:0] aOp_q,      aOp_d;
    logic [31:0] bOp_q,      bOp_d;
    logic [63:0] product_q,  product_d;
    logic        outValid_q, outValid_d;

    logic [15:0] coreA;
    logic [15:0] coreB;
    logic [31:0] coreOut;
    logic [63:0] partial;
    logic [63:0] accSum;

    // Step selects which operand halves feed the core and the weight of the result.
    always_comb begin
        coreA   = aOp_q[15:0];
        coreB   = bOp_q[15:0];
        partial = {32'b0, coreOut};
        case (step_q)
            2'd0: begin
                coreA   = aOp_q[15:0];
                coreB   = bOp_q[15:0];
                partial = {32'b0, coreOut};
            end
            2'd1: begin
                coreA   = aOp_q[31:16];
                coreB   = bOp_q[15:0];
                partial = {16'b0, coreOut, 16'b0};
            end
            2'd2: begin
                coreA   = aOp_q[15:0];
                coreB   = bOp_q[31:16];
                partial = {16'b0, coreOut, 16'b0};
            end
            default: begin
                coreA   = aOp_q[31:16];
                coreB   = bOp_q[31:16];
                partial = {coreOut, 32'b0};
            end
        endcase
    end

    vedic_16x16 uCore (.a_i(coreA), .b_i(coreB), .p_o(coreOut));

    assign accSum = acc_q + partial;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= 2'd0;
            acc_q      <= 64'd0;
            aOp_q      <= 32'd0;
            bOp_q      <= 32'd0;
            product_q  <= 64'd0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            aOp_q      <= aOp_d;
            bOp_q      <= bOp_d;
            product_q  <= product_d;
            outValid_q <= outValid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        acc_d      = acc_q;
        aOp_d      = aOp_q;
        bOp_d      = bOp_q;
        product_d  = product_q;
        outValid_d = outValid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    aOp_d  = a;
                    bOp_d  = b;
                    acc_d  = 64'd0;
                    step_d = 2'd0;
                    if (ZERO_SKIP && ((a == 32'd0) || (b == 32'd0))) begin
                        state_d    = DONE;
                        product_d  = 64'd0;
                        outValid_d = 1'b1;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                acc_d  = accSum;
                step_d = step_q + 2'd1;
                // The last partial product goes straight into the output register.
                if (step_q == 2'd3) begin
                    state_d    = DONE;
                    product_d  = accSum;
                    outValid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d    = IDLE;
                    outValid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = outValid_q;
    assign product   = product_q;
endmodule

// File: tb/tb_vedic_mul32_seq.sv
// Self-checking bench for vedic_mul32_seq: directed vector table, hand-written
// backpressure/reset sequences, and randomized operands against a plain a*b model.
module tb_vedic_mul32_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        outReady;
    logic        useNoSkip;

    logic        inValidSkip, inValidNoSkip;
    logic        inReadySkip, inReadyNoSkip;
    logic        outValidSkip, outValidNoSkip;
    logic [63:0] productSkip, productNoSkip;
    logic        busySkip, busyNoSkip;

    logic        inReadySel, outValidSel, busySel;
    logic [63:0] productSel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        int          lat;
        bit          noSkip;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    // Only the selected instance sees in_valid; the other idles.
    assign inValidSkip   = inValid & ~useNoSkip;
    assign inValidNoSkip = inValid & useNoSkip;
    assign inReadySel    = useNoSkip ? inReadyNoSkip  : inReadySkip;
    assign outValidSel   = useNoSkip ? outValidNoSkip : outValidSkip;
    assign busySel       = useNoSkip ? busyNoSkip     : busySkip;
    assign productSel    = useNoSkip ? productNoSkip  : productSkip;

    vedic_mul32_seq #(.ZERO_SKIP(1'b1)) dutSkip (
        .clk(clk), .rst(rst), .in_valid(inValidSkip), .in_ready(inReadySkip),
        .a(aIn), .b(bIn), .out_valid(outValidSkip), .out_ready(outReady),
        .product(productSkip), .busy(busySkip)
    );

    vedic_mul32_seq #(.ZERO_SKIP(1'b0)) dutNoSkip (
        .clk(clk), .rst(rst), .in_valid(inValidNoSkip), .in_ready(inReadyNoSkip),
        .a(aIn), .b(bIn), .out_valid(outValidNoSkip), .out_ready(outReady),
        .product(productNoSkip), .busy(busyNoSkip)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) nextCycle();
        rst = 1'b0;
    endtask

    // One complete transaction with out_ready high: accept, measure latency,
    // check the product and that out_valid lasts a single cycle.
    task automatic applyStimulus(input string name, input bit noSkip, input logic [31:0] ta,
                                 input logic [31:0] tb, input logic [63:0] expProd, input int expLat);
        int wait_n;
        int lat;
        useNoSkip = noSkip;
        outReady  = 1'b1;
        wait_n = 0;
        while (!inReadySel && wait_n < 20) begin
            nextCycle();
            wait_n++;
        end
        checkOutput({name, "_inReady"}, 64'(inReadySel), 64'd1);
        aIn     = ta;
        bIn     = tb;
        inValid = 1'b1;
        nextCycle();
        inValid = 1'b0;
        aIn     = $urandom;
        bIn     = $urandom;
        if (expLat > 1) checkOutput({name, "_busy"}, 64'(busySel), 64'd1);
        lat = 1;
        while (!outValidSel && lat < 20) begin
            nextCycle();
            lat++;
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
        checkOutput({name, "_product"}, productSel, expProd);
        nextCycle();
        checkOutput({name, "_oneCycle"}, 64'(outValidSel), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rsel;
        int          wait_n;

        rst = 1'b0; inValid = 1'b0; aIn = '0; bIn = '0; outReady = 1'b1; useNoSkip = 1'b0;

        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 5, 1'b0};
        vecs[1] = '{32'h0000FFFF, 32'hFFFF0000, 64'h0000FFFE00010000, 5, 1'b0};
        vecs[2] = '{32'h00010000, 32'h00010000, 64'h0000000100000000, 5, 1'b0};
        vecs[3] = '{32'h00000000, 32'h12345678, 64'h0, 1, 1'b0};
        vecs[4] = '{32'h00000000, 32'h12345678, 64'h0, 5, 1'b1};
        vecs[5] = '{32'h00000003, 32'h00000005, 64'hF, 5, 1'b0};
        vecs[6] = '{32'h12345678, 32'h00000000, 64'h0, 1, 1'b0};
        vecs[7] = '{32'h00000001, 32'h00000001, 64'h1, 5, 1'b1};
        vecs[8] = '{32'h00000000, 32'h00000000, 64'h0, 5, 1'b1};
        vecs[9] = '{32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001, 5, 1'b1};

        // Reset, then a stretch of idle cycles with nothing offered.
        applyReset(2);
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("idle%0d_outValid", c), {62'd0, outValidSkip, outValidNoSkip}, 64'd0);
            checkOutput($sformatf("idle%0d_inReady", c), {62'd0, inReadySkip, inReadyNoSkip}, 64'd3);
            checkOutput($sformatf("idle%0d_busy", c), {62'd0, busySkip, busyNoSkip}, 64'd0);
            checkOutput($sformatf("idle%0d_product", c), productSkip | productNoSkip, 64'd0);
            nextCycle();
        end

        for (int i = 0; i < 10; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].noSkip, vecs[i].a, vecs[i].b,
                          vecs[i].prod, vecs[i].lat);

        // Backpressure: result must hold while new operands are offered and refused.
        useNoSkip = 1'b0;
        outReady  = 1'b0;
        aIn = 32'd3; bIn = 32'd5; inValid = 1'b1;
        nextCycle();
        inValid = 1'b0;
        wait_n = 0;
        while (!outValidSel && wait_n < 20) begin
            nextCycle();
            wait_n++;
        end
        checkOutput("bp_reached", 64'(outValidSel), 64'd1);
        aIn = 32'd7; bIn = 32'd7; inValid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("bp%0d_outValid", c), 64'(outValidSel), 64'd1);
            checkOutput($sformatf("bp%0d_product", c), productSel, 64'd15);
            checkOutput($sformatf("bp%0d_inReady", c), 64'(inReadySel), 64'd0);
            nextCycle();
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("bp_xfer_valid", 64'(outValidSel), 64'd1);
        checkOutput("bp_xfer_product", productSel, 64'd15);
        nextCycle();
        checkOutput("bp_after_valid", 64'(outValidSel), 64'd0);
        checkOutput("bp_after_inReady", 64'(inReadySel), 64'd1);
        checkOutput("bp_after_product", productSel, 64'd15);

        // Reset during the third MUL step discards the operation entirely.
        aIn = 32'hDEADBEEF; bIn = 32'd2; inValid = 1'b1;
        nextCycle();
        inValid = 1'b0;
        repeat (2) nextCycle();
        applyReset(1);
        checkOutput("rstmid_busy", 64'(busySel), 64'd0);
        checkOutput("rstmid_inReady", 64'(inReadySel), 64'd1);
        checkOutput("rstmid_product", productSel, 64'd0);
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("rstmid%0d_outValid", c), 64'(outValidSel), 64'd0);
            nextCycle();
        end
        applyStimulus("postRst", 1'b0, 32'd2, 32'h80000000, 64'h0000000100000000, 5);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rsel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) ra = 32'd0;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFF;
            applyStimulus($sformatf("rand%0d", i), rsel, ra, rb, {32'd0, ra} * {32'd0, rb},
                          (!rsel && (ra == 32'd0 || rb == 32'd0)) ? 1 : 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
